// File: rtl/move_scheduler_pkg.sv
// Command codes, scheduler state encoding and fixed-priority pick, shared with game control.
package tetris_pkg;

  localparam logic [2:0] CMD_NONE    = 3'd0;
  localparam logic [2:0] CMD_LEFT    = 3'd1;
  localparam logic [2:0] CMD_RIGHT   = 3'd2;
  localparam logic [2:0] CMD_ROTATE  = 3'd3;
  localparam logic [2:0] CMD_GRAVITY = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_HALT  = 2'd2
  } sched_state_e;

  // Pending bit i belongs to command code i+1; GRAVITY > ROTATE > LEFT > RIGHT.
  function automatic logic [2:0] pick_cmd(input logic [3:0] pend);
    if (pend[3]) return CMD_GRAVITY;
    if (pend[2]) return CMD_ROTATE;
    if (pend[0]) return CMD_LEFT;
    if (pend[1]) return CMD_RIGHT;
    return CMD_NONE;
  endfunction

endpackage

// File: rtl/move_scheduler_if.sv
// Single valid/ready command channel from the move scheduler to game control.
// cmd is stable while cmd_valid is high and cmd_ready is low.
interface move_scheduler_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd;

  modport master (output cmd_valid, output cmd, input cmd_ready);
  modport slave  (input cmd_valid, input cmd, output cmd_ready);
endinterface

// File: rtl/move_scheduler_repeat_timer.sv
// Key edge detect plus DAS delay/rate auto-repeat; fire_o is a same-cycle request pulse.
// No backpressure: the parent coalesces fire_o into its pending flag.
module repeat_timer #(
  parameter int DAS_DELAY = 15_000_000,
  parameter int DAS_RATE  = 4_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic key_i,
  input  logic pause_i,
  input  logic cancel_i,
  output logic rise_o,
  output logic fire_o
);
  localparam int DW = (DAS_DELAY > 1) ? $clog2(DAS_DELAY) : 1;
  localparam int RW = (DAS_RATE > 1) ? $clog2(DAS_RATE) : 1;
  localparam logic [DW-1:0] DLY_LAST  = DW'(DAS_DELAY - 1);
  localparam logic [RW-1:0] RATE_LAST = RW'(DAS_RATE - 1);

  logic          key_q;
  logic          act_q, act_d;
  logic          rep_q, rep_d;
  logic [DW-1:0] dly_q, dly_d;
  logic [RW-1:0] rate_q, rate_d;

  assign rise_o = key_i & ~key_q;

  always_comb begin
    act_d  = act_q;
    rep_d  = rep_q;
    dly_d  = dly_q;
    rate_d = rate_q;
    fire_o = 1'b0;
    if (!key_i) begin
      act_d  = 1'b0;
      rep_d  = 1'b0;
      dly_d  = '0;
      rate_d = '0;
    end else if (!pause_i) begin
      // A cancelled press (both sides at once) never arms the timer.
      if (rise_o) begin
        act_d  = ~cancel_i;
        rep_d  = 1'b0;
        dly_d  = '0;
        rate_d = '0;
        fire_o = ~cancel_i;
      end else if (act_q && !rep_q) begin
        dly_d = dly_q + 1'b1;
        if (dly_d == DLY_LAST) begin
          rep_d  = 1'b1;
          fire_o = 1'b1;
        end
      end else if (rep_q) begin
        if (rate_q == RATE_LAST) begin
          rate_d = '0;
          fire_o = 1'b1;
        end else begin
          rate_d = rate_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_q  <= 1'b0;
      act_q  <= 1'b0;
      rep_q  <= 1'b0;
      dly_q  <= '0;
      rate_q <= '0;
    end else begin
      key_q  <= key_i;
      act_q  <= act_d;
      rep_q  <= rep_d;
      dly_q  <= dly_d;
      rate_q <= rate_d;
    end
  end

endmodule

// File: rtl/move_scheduler.sv
// Merges gravity, rotate and auto-repeated left/right into one command stream; SOFT_DROP_EN shortens gravity while key_down is held.
// cmd_valid rises one cycle after a request is pending and holds until cmd_ready; requests coalesce per source meanwhile.
module move_scheduler
  import tetris_pkg::*;
#(
  parameter int GRAVITY_TICKS   = 50_000_000,
  parameter int DAS_DELAY       = 15_000_000,
  parameter int DAS_RATE        = 4_000_000,
  parameter int SOFT_DROP_TICKS = 5_000_000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              key_left,
  input  logic              key_right,
  input  logic              key_up,
  input  logic              key_down,
  input  logic              pause,
  input  logic              fail,
  move_scheduler_if.master  cmd_if,
  output logic              halted
);
  localparam int GW = (GRAVITY_TICKS > 1) ? $clog2(GRAVITY_TICKS) : 1;
  localparam logic [GW-1:0] GRAV_TC = GW'(GRAVITY_TICKS - 1);

  sched_state_e  state_q, state_d;
  logic [2:0]    cmd_q, cmd_d, sel_cmd;
  logic [3:0]    pend_q, pend_d, pend_set, pend_clr;
  logic [GW-1:0] grav_q, grav_d, grav_tc;
  logic          grav_fire;
  logic          up_q;
  logic          rise_l, rise_r, fire_l, fire_r, cancel_lr;

`ifdef SOFT_DROP_EN
  localparam logic [GW-1:0] SOFT_TC = GW'(SOFT_DROP_TICKS - 1);
  assign grav_tc = key_down ? SOFT_TC : GRAV_TC;
`else
  logic soft_drop_unused;
  assign soft_drop_unused = key_down ^ (SOFT_DROP_TICKS == 0);
  assign grav_tc = GRAV_TC;
`endif

  // >= lets a shortened terminal count wrap at once when the count is already past it.
  always_comb begin
    grav_d    = grav_q;
    grav_fire = 1'b0;
    if (!pause) begin
      if (grav_q >= grav_tc) begin
        grav_d    = '0;
        grav_fire = 1'b1;
      end else begin
        grav_d = grav_q + 1'b1;
      end
    end
  end

  assign cancel_lr = rise_l & rise_r;

  repeat_timer #(.DAS_DELAY(DAS_DELAY), .DAS_RATE(DAS_RATE)) u_rep_left (
    .clk(clk), .rst(rst), .key_i(key_left), .pause_i(pause),
    .cancel_i(cancel_lr), .rise_o(rise_l), .fire_o(fire_l)
  );

  repeat_timer #(.DAS_DELAY(DAS_DELAY), .DAS_RATE(DAS_RATE)) u_rep_right (
    .clk(clk), .rst(rst), .key_i(key_right), .pause_i(pause),
    .cancel_i(cancel_lr), .rise_o(rise_r), .fire_o(fire_r)
  );

  assign pend_set = {grav_fire, key_up & ~up_q & ~pause, fire_r, fire_l};
  assign pend_d   = (pend_q & ~pend_clr) | pend_set;

  always_comb begin
    state_d  = state_q;
    cmd_d    = cmd_q;
    pend_clr = '0;
    sel_cmd  = pick_cmd(pend_q);
    case (state_q)
      ST_IDLE: begin
        if (!pause && (pend_q != 4'b0000)) begin
          state_d = ST_ISSUE;
          cmd_d   = sel_cmd;
          case (sel_cmd)
            CMD_LEFT:    pend_clr = 4'b0001;
            CMD_RIGHT:   pend_clr = 4'b0010;
            CMD_ROTATE:  pend_clr = 4'b0100;
            CMD_GRAVITY: pend_clr = 4'b1000;
            default:     pend_clr = 4'b0000;
          endcase
        end
      end
      ST_ISSUE: begin
        if (cmd_if.cmd_ready) begin
          state_d = ST_IDLE;
          cmd_d   = CMD_NONE;
        end
      end
      ST_HALT: cmd_d = CMD_NONE;
      default: begin
        state_d = ST_IDLE;
        cmd_d   = CMD_NONE;
      end
    endcase
    if (fail) begin
      state_d  = ST_HALT;
      cmd_d    = CMD_NONE;
      pend_clr = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cmd_q   <= CMD_NONE;
      pend_q  <= '0;
      grav_q  <= '0;
      up_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      pend_q  <= pend_d;
      grav_q  <= grav_d;
      up_q    <= key_up;
    end
  end

  assign cmd_if.cmd_valid = (state_q == ST_ISSUE);
  assign cmd_if.cmd       = cmd_q;
  assign halted           = (state_q == ST_HALT);

endmodule

// File: tb/tb_move_scheduler.sv
// Bench for move_scheduler: event-level reference model plus directed timing scenarios.
module tb_move_scheduler;
  localparam int GRAV  = 20;
  localparam int DAS_D = 8;
  localparam int DAS_R = 3;
  localparam int SOFTD = 4;

  logic clk, rst;
  logic key_l, key_r, key_u, key_d, pause, fail, ready;
  logic halted;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  move_scheduler_if bus ();
  assign bus.cmd_ready = ready;

  move_scheduler #(
    .GRAVITY_TICKS(GRAV), .DAS_DELAY(DAS_D), .DAS_RATE(DAS_R), .SOFT_DROP_TICKS(SOFTD)
  ) dut (
    .clk(clk), .rst(rst), .key_left(key_l), .key_right(key_r), .key_up(key_u),
    .key_down(key_d), .pause(pause), .fail(fail), .cmd_if(bus), .halted(halted)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: elapsed unpaused cycles per source, a pending set and a 3-phase issuer.
  int m_gel;
  int m_age [2];
  bit m_act [2];
  bit m_prev[3];
  bit m_pend[5];
  int m_phase;   // 0 idle, 1 offering, 2 halted
  int m_cmd;

  task automatic model_reset();
    m_gel = 0; m_phase = 0; m_cmd = 0;
    for (int i = 0; i < 2; i++) begin m_age[i] = 0; m_act[i] = 0; end
    for (int i = 0; i < 3; i++) m_prev[i] = 0;
    for (int i = 0; i < 5; i++) m_pend[i] = 0;
  endtask

  task automatic model_step();
    bit f[5];
    bit k[2];
    bit rs[2];
    bit ru, both, found;
    int per;
    int prio[4];
    prio = '{4, 3, 1, 2};
    for (int i = 0; i < 5; i++) f[i] = 0;
    per = GRAV;
`ifdef SOFT_DROP_EN
    if (key_d) per = SOFTD;
`endif
    if (!pause) begin
      m_gel++;
      if (m_gel >= per) begin f[4] = 1; m_gel = 0; end
    end
    k[0] = key_l; k[1] = key_r;
    rs[0] = key_l && !m_prev[0];
    rs[1] = key_r && !m_prev[1];
    ru    = key_u && !m_prev[2];
    both  = rs[0] && rs[1];
    for (int s = 0; s < 2; s++) begin
      if (!k[s]) begin
        m_act[s] = 0; m_age[s] = 0;
      end else if (!pause) begin
        if (rs[s]) begin
          m_act[s] = !both; m_age[s] = 0;
          if (!both) f[s+1] = 1;
        end else if (m_act[s]) begin
          m_age[s]++;
          if (m_age[s] == DAS_D - 1 ||
              (m_age[s] > DAS_D - 1 && (m_age[s] - (DAS_D - 1)) % DAS_R == 0))
            f[s+1] = 1;
        end
      end
    end
    if (!pause && ru) f[3] = 1;
    m_prev[0] = key_l; m_prev[1] = key_r; m_prev[2] = key_u;
    if (fail) begin
      m_phase = 2; m_cmd = 0;
    end else if (m_phase == 0 && !pause) begin
      found = 0;
      for (int i = 0; i < 4; i++)
        if (!found && m_pend[prio[i]]) begin
          found = 1; m_cmd = prio[i]; m_pend[prio[i]] = 0; m_phase = 1;
        end
    end else if (m_phase == 1 && ready) begin
      m_cmd = 0; m_phase = 0;
    end
    for (int c = 1; c < 5; c++) if (f[c]) m_pend[c] = 1;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    rst = 1; key_l = 0; key_r = 0; key_u = 0; key_d = 0; pause = 0; fail = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 0;
    model_reset();
    cyc = 0;
  endtask

  task automatic test_reset();
    rst = 1; key_l = 0; key_r = 0; key_u = 0; key_d = 0; pause = 0; fail = 0; ready = 1;
    #2;
    checks++;
    if (bus.cmd_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b want=0", bus.cmd_valid); end
    checks++;
    if (bus.cmd !== 3'd0) begin errors++; $display("FAIL reset_cmd got=%0d want=0", bus.cmd); end
    checks++;
    if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted got=%b want=0", halted); end
    do_reset();
  endtask

  task automatic test_gravity();
    int first, second;
    first = -1; second = -1; ready = 1;
    for (int i = 0; i < 45; i++) begin
      tick();
      checks++;
      if (bus.cmd_valid !== (m_phase == 1) || bus.cmd !== 3'(m_cmd) || halted !== (m_phase == 2)) begin
        errors++;
        $display("FAIL gravity_model cyc=%0d got vld=%b cmd=%0d halt=%b want vld=%b cmd=%0d halt=%b",
                 cyc, bus.cmd_valid, bus.cmd, halted, m_phase == 1, m_cmd, m_phase == 2);
      end
      if (bus.cmd_valid === 1'b1 && bus.cmd === 3'd4) begin
        if (first < 0) first = cyc; else if (second < 0) second = cyc;
      end
    end
    checks++;
    if (first != GRAV + 1) begin errors++; $display("FAIL gravity_first got=%0d want=%0d", first, GRAV + 1); end
    checks++;
    if (second != 2 * GRAV + 1) begin errors++; $display("FAIL gravity_second got=%0d want=%0d", second, 2 * GRAV + 1); end
  endtask

  task automatic test_rotate();
    int wrap, g, r, nrot;
    g = -1; r = -1; nrot = 0;
    while ((cyc + 1) % GRAV != 0) tick();
    wrap = cyc + 1;
    for (int i = 0; i < 9; i++) begin
      key_u = (i == 0);
      tick();
      if (bus.cmd_valid === 1'b1 && bus.cmd === 3'd4 && g < 0) g = cyc;
      if (bus.cmd_valid === 1'b1 && bus.cmd === 3'd3) begin nrot++; if (r < 0) r = cyc; end
    end
    key_u = 0;
    checks++;
    if (g != wrap + 1) begin errors++; $display("FAIL rotate_grav_first got=%0d want=%0d", g, wrap + 1); end
    checks++;
    if (r != wrap + 3) begin errors++; $display("FAIL rotate_after_grav got=%0d want=%0d", r, wrap + 3); end
    checks++;
    if (nrot != 1) begin errors++; $display("FAIL rotate_count got=%0d want=1", nrot); end
  endtask

  task automatic test_das();
    int n, p, rel, late, got;
    int lq[$];
    int exp_off[4];
    exp_off = '{1, DAS_D, DAS_D + DAS_R, DAS_D + 2 * DAS_R};
    n = 0; late = 0;
    while (!(bus.cmd_valid === 1'b1 && bus.cmd === 3'd4) && n < 25) begin tick(); n++; end
    checks++;
    if (n >= 25) begin errors++; $display("FAIL das_wait_gravity got=timeout want=gravity"); end
    key_l = 1;
    p = cyc + 1;
    for (int i = 0; i < 30; i++) begin
      tick();
      checks++;
      if (bus.cmd_valid !== (m_phase == 1) || bus.cmd !== 3'(m_cmd) || halted !== (m_phase == 2)) begin
        errors++;
        $display("FAIL das_model cyc=%0d got vld=%b cmd=%0d want vld=%b cmd=%0d",
                 cyc, bus.cmd_valid, bus.cmd, m_phase == 1, m_cmd);
      end
      if (bus.cmd_valid === 1'b1 && bus.cmd === 3'd1) lq.push_back(cyc);
    end
    key_l = 0;
    rel = cyc;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (cyc > rel + 2 && bus.cmd_valid === 1'b1 && bus.cmd === 3'd1) late++;
    end
    for (int k = 0; k < 4; k++) begin
      got = (k < lq.size()) ? lq[k] - p : -1;
      checks++;
      if (got != exp_off[k]) begin errors++; $display("FAIL das_offset%0d got=%0d want=%0d", k, got, exp_off[k]); end
    end
    checks++;
    if (late != 0) begin errors++; $display("FAIL das_after_release got=%0d want=0", late); end
  endtask

  task automatic test_simul();
    int nlr;
    nlr = 0;
    repeat ($urandom_range(0, 5)) tick();
    key_l = 1; key_r = 1;
    for (int i = 0; i < 17; i++) begin
      if (i == 14) begin key_l = 0; key_r = 0; end
      tick();
      checks++;
      if (bus.cmd_valid !== (m_phase == 1) || bus.cmd !== 3'(m_cmd)) begin
        errors++;
        $display("FAIL simul_model cyc=%0d got vld=%b cmd=%0d want vld=%b cmd=%0d",
                 cyc, bus.cmd_valid, bus.cmd, m_phase == 1, m_cmd);
      end
      if (bus.cmd_valid === 1'b1 && (bus.cmd === 3'd1 || bus.cmd === 3'd2)) nlr++;
    end
    checks++;
    if (nlr != 0) begin errors++; $display("FAIL simul_lr_count got=%0d want=0", nlr); end
  endtask

  task automatic test_pause();
    int n, g, g2, pv, nrot;
    n = 0; pv = 0; nrot = 0; g2 = -1;
    while (!(bus.cmd_valid === 1'b1 && bus.cmd === 3'd4) && n < 25) begin tick(); n++; end
    checks++;
    if (n >= 25) begin errors++; $display("FAIL pause_wait_gravity got=timeout want=gravity"); end
    g = cyc;
    repeat (5) tick();
    pause = 1;
    for (int i = 0; i < 15; i++) begin
      if (i == 5) key_u = 1;
      tick();
      checks++;
      if (bus.cmd_valid !== (m_phase == 1) || bus.cmd !== 3'(m_cmd)) begin
        errors++;
        $display("FAIL pause_model cyc=%0d got vld=%b cmd=%0d want vld=%b cmd=%0d",
                 cyc, bus.cmd_valid, bus.cmd, m_phase == 1, m_cmd);
      end
      if (bus.cmd_valid === 1'b1) pv++;
    end
    pause = 0;
    n = 0;
    while (g2 < 0 && n < 40) begin
      tick(); n++;
      if (bus.cmd_valid === 1'b1 && bus.cmd === 3'd3) nrot++;
      if (bus.cmd_valid === 1'b1 && bus.cmd === 3'd4) g2 = cyc;
    end
    key_u = 0;
    checks++;
    if (pv != 0) begin errors++; $display("FAIL pause_no_cmd got=%0d want=0", pv); end
    checks++;
    if (g2 - g != GRAV + 15) begin errors++; $display("FAIL pause_resume_gap got=%0d want=%0d", g2 - g, GRAV + 15); end
    checks++;
    if (nrot != 0) begin errors++; $display("FAIL pause_held_rotate got=%0d want=0", nrot); end
`ifdef SOFT_DROP_EN
    begin
      int gq[$];
      int bad;
      bad = 0;
      key_d = 1;
      for (int i = 0; i < 25; i++) begin
        tick();
        if (bus.cmd_valid === 1'b1 && bus.cmd === 3'd4) gq.push_back(cyc);
      end
      for (int i = 1; i < gq.size(); i++) if (gq[i] - gq[i-1] != SOFTD) bad++;
      checks++;
      if (gq.size() < 5 || bad != 0) begin
        errors++; $display("FAIL soft_drop_period got=%0d_events_%0d_bad want=>=5_events_0_bad", gq.size(), bad);
      end
      pause = 1; pv = 0;
      tick();
      repeat (14) begin tick(); if (bus.cmd_valid === 1'b1) pv++; end
      pause = 0; key_d = 0;
      checks++;
      if (pv != 0) begin errors++; $display("FAIL soft_drop_pause got=%0d want=0", pv); end
    end
`endif
  endtask

  task automatic test_backpressure_fail();
    int n, unstable, nv;
    logic [2:0] saved;
    n = 0; unstable = 0; nv = 0;
    ready = 0;
    while (bus.cmd_valid !== 1'b1 && n < 25) begin tick(); n++; end
    checks++;
    if (n >= 25) begin errors++; $display("FAIL bp_wait_valid got=timeout want=valid"); end
    saved = bus.cmd;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus.cmd_valid !== 1'b1 || bus.cmd !== saved) unstable++;
    end
    checks++;
    if (unstable != 0) begin errors++; $display("FAIL bp_stable got=%0d_unstable want=0", unstable); end
    ready = 1;
    tick();
    checks++;
    if (bus.cmd_valid !== 1'b0) begin errors++; $display("FAIL bp_transfer got vld=%b want=0", bus.cmd_valid); end
    ready = 0; n = 0;
    while (bus.cmd_valid !== 1'b1 && n < 25) begin tick(); n++; end
    checks++;
    if (n >= 25) begin errors++; $display("FAIL fail_wait_valid got=timeout want=valid"); end
    fail = 1;
    tick();
    fail = 0;
    checks++;
    if (bus.cmd_valid !== 1'b0 || halted !== 1'b1) begin
      errors++; $display("FAIL fail_halt got vld=%b halted=%b want vld=0 halted=1", bus.cmd_valid, halted);
    end
    ready = 1;
    for (int i = 0; i < 30; i++) begin
      key_l = 1'($urandom_range(0, 1)); key_r = 1'($urandom_range(0, 1)); key_u = 1'($urandom_range(0, 1));
      tick();
      checks++;
      if (bus.cmd_valid !== (m_phase == 1) || halted !== (m_phase == 2)) begin
        errors++; $display("FAIL halt_model cyc=%0d got vld=%b halted=%b want vld=%b halted=%b",
                           cyc, bus.cmd_valid, halted, m_phase == 1, m_phase == 2);
      end
      if (bus.cmd_valid === 1'b1) nv++;
    end
    checks++;
    if (nv != 0) begin errors++; $display("FAIL halt_no_cmd got=%0d want=0", nv); end
  endtask

  task automatic test_async_reset();
    int n;
    n = 0;
    do_reset();
    #1;
    checks++;
    if (halted !== 1'b0) begin errors++; $display("FAIL areset_unhalt got=%b want=0", halted); end
    ready = 0;
    while (bus.cmd_valid !== 1'b1 && n < 25) begin tick(); n++; end
    checks++;
    if (n >= 25) begin errors++; $display("FAIL areset_wait_valid got=timeout want=valid"); end
    #3;
    rst = 1;
    #1;
    checks++;
    if (bus.cmd_valid !== 1'b0 || bus.cmd !== 3'd0) begin
      errors++; $display("FAIL areset_drop got vld=%b cmd=%0d want vld=0 cmd=0", bus.cmd_valid, bus.cmd);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 0;
    model_reset();
    cyc = 0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 7) == 0) key_l = ~key_l;
      if ($urandom_range(0, 7) == 0) key_r = ~key_r;
      if ($urandom_range(0, 9) == 0) key_u = ~key_u;
      if ($urandom_range(0, 15) == 0) key_d = ~key_d;
      if ($urandom_range(0, 31) == 0 && !key_l && !key_r) begin key_l = 1; key_r = 1; end
      if ($urandom_range(0, 19) == 0) pause = ~pause;
      ready = ($urandom_range(0, 3) != 0);
      tick();
      checks++;
      if (bus.cmd_valid !== (m_phase == 1) || bus.cmd !== 3'(m_cmd) || halted !== (m_phase == 2)) begin
        errors++;
        $display("FAIL random_model cyc=%0d got vld=%b cmd=%0d halt=%b want vld=%b cmd=%0d halt=%b",
                 cyc, bus.cmd_valid, bus.cmd, halted, m_phase == 1, m_cmd, m_phase == 2);
      end
    end
  endtask

  initial begin
    test_reset();
    test_gravity();
    test_rotate();
    test_das();
    test_simul();
    test_pause();
    test_backpressure_fail();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
